glb_mc_controller: RTL and testbench

- Per-PE multicast controller that sits directly downstream of the global PE bus. It consumes the ifmap, filter and psum beats broadcast on that bus.
- It accepts a beat only when the beat's TAG matches the controller's configured ID. Accepted beats are buffered in a small first-word-fall-through (FWFT) FIFO.
- Buffered beats are delivered to one processing element through a valid/ready handshake.
- One instance exists per PE column. Its backpressure is returned on the bus READY line.

---
 rtl/glb_mc_controller_if.sv | 72 +++++++
 rtl/glb_mc_controller.sv | 192 +++++++++++++++++++
 tb/tb_glb_mc_controller.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_mc_controller_if.sv
// -----------------------------------------------------------------------------
// glb_mc_controller_if
//
// Purpose
//   Bundles the two beat channels around one multicast controller:
//     * the global PE bus side (ifmap/filter/psum broadcast, tag, READY
//       backpressure back to the bus), and
//     * the PE side (FWFT head beat with a valid/ready handshake).
//
// Modports
//   slave  : the controller. It receives bus beats, drives bus_ready, drives
//            the pe_* head beat and receives pe_ready.
//   master : the environment (global bus plus PE). It drives bus beats and
//            pe_ready and observes bus_ready and the pe_* outputs.
//
// Parameters
//   DATA_WIDTH : ifmap/filter word width; psum is 2*DATA_WIDTH.
//   NUM_COL    : number of PE columns; sets the tag width.
// -----------------------------------------------------------------------------
interface glb_mc_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4
);

  // A single-column system still carries a 1-bit tag so nothing collapses to
  // zero width.
  localparam int TAG_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

  // Global PE bus side
  logic                    bus_valid;
  logic [TAG_W-1:0]        bus_tag;
  logic [DATA_WIDTH-1:0]   bus_ifmap;
  logic [DATA_WIDTH-1:0]   bus_fltr;
  logic [2*DATA_WIDTH-1:0] bus_psum;
  logic                    bus_ready;

  // Processing-element side
  logic                    pe_valid;
  logic                    pe_ready;
  logic [DATA_WIDTH-1:0]   pe_ifmap;
  logic [DATA_WIDTH-1:0]   pe_fltr;
  logic [2*DATA_WIDTH-1:0] pe_psum;

  modport slave (
    input  bus_valid,
    input  bus_tag,
    input  bus_ifmap,
    input  bus_fltr,
    input  bus_psum,
    output bus_ready,
    output pe_valid,
    input  pe_ready,
    output pe_ifmap,
    output pe_fltr,
    output pe_psum
  );

  modport master (
    output bus_valid,
    output bus_tag,
    output bus_ifmap,
    output bus_fltr,
    output bus_psum,
    input  bus_ready,
    input  pe_valid,
    output pe_ready,
    input  pe_ifmap,
    input  pe_fltr,
    input  pe_psum
  );

endinterface : glb_mc_controller_if

// File: rtl/glb_mc_controller.sv
// -----------------------------------------------------------------------------
// glb_mc_controller
//
// Purpose
//   Per-PE-column multicast controller located directly downstream of the
//   global PE bus. Each bus beat carries a destination tag. A beat whose tag
//   matches this controller's ID is captured into a small first-word-fall-
//   through FIFO. The head of that FIFO is offered to the processing element
//   through a valid/ready handshake. While the FIFO is full, backpressure is
//   returned on bus_ready.
//
// Ports
//   clk         : single clock, all state updates on the rising edge.
//   rst         : synchronous, active-high reset.
//   cfg_id_we   : load cfg_id into the ID register. The new ID is used for
//                 tag compare from the following cycle onwards.
//   cfg_id      : controller ID value.
//   flush       : synchronous FIFO clear. A push in the same cycle is dropped.
//   bus_pe      : slave view of the bus/PE beat interface
//                   bus_valid/bus_tag/bus_ifmap/bus_fltr/bus_psum/bus_ready
//                   pe_valid/pe_ready/pe_ifmap/pe_fltr/pe_psum
//   fifo_count  : current FIFO occupancy, 0..FIFO_DEPTH.
//   accept_cnt  : number of accepted beats, wrapping modulo 2^16.
//
// Parameters
//   DATA_WIDTH  : ifmap/filter width; psum is 2*DATA_WIDTH.
//   NUM_COL     : number of PE columns; ID/tag are $clog2(NUM_COL) bits.
//   FIFO_DEPTH  : number of beat entries; power of two, at least 2. The
//                 pointers rely on natural binary wrap.
// -----------------------------------------------------------------------------
module glb_mc_controller #(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_COL    = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int TAG_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_id_we,
  input  logic [TAG_W-1:0]       cfg_id,
  input  logic                   flush,
  glb_mc_controller_if.slave     bus_pe,
  output logic [CNT_W-1:0]       fifo_count,
  output logic [15:0]            accept_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // One buffered beat. The psum field is placed last so that the packed
  // layout reads ifmap, fltr, psum from the most significant bit down.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]   ifmap;
    logic [DATA_WIDTH-1:0]   fltr;
    logic [2*DATA_WIDTH-1:0] psum;
  } beat_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  beat_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_nxt;
  logic [TAG_W-1:0]   id_q;
  logic [15:0]        accept_q;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic  full;
  logic  empty;
  logic  tag_hit;
  logic  push;
  logic  pop;
  beat_t beat_in;
  beat_t head;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // The tag compare uses the registered ID. A cfg_id_we in this cycle only
  // takes effect after the edge, so the beat seen in the same cycle is still
  // judged against the old ID.
  assign tag_hit = (bus_pe.bus_tag == id_q);

  // bus_ready depends only on occupancy, never on bus_valid or bus_tag.
  // This keeps the bus READY line free of any combinational path from the
  // bus inputs.
  assign bus_pe.bus_ready = ~full;

  // A push that coincides with a flush is dropped entirely. This is why flush
  // is folded into push itself: the same signal gates the storage write, the
  // write pointer and accept_cnt.
  assign push = bus_pe.bus_valid & ~full & tag_hit & ~flush;

  // A pop is only possible when the FIFO holds a beat. Overflow and underflow
  // therefore cannot happen, and the count needs no saturation.
  assign pop  = ~empty & bus_pe.pe_ready;

  assign beat_in = '{ifmap: bus_pe.bus_ifmap,
                     fltr:  bus_pe.bus_fltr,
                     psum:  bus_pe.bus_psum};

  // ---------------------------------------------------------------------------
  // Occupancy next-state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default on its first
  // line. A path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;   // idle, or push and pop together
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state: ID, pointers, occupancy, accept counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking assignments.
  // All registers then sample pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      accept_q <= '0;
    end else begin
      if (cfg_id_we) begin
        id_q <= cfg_id;
      end

      // push is already suppressed under flush, so a dropped beat never counts.
      if (push) begin
        accept_q <= accept_q + 16'd1;
      end

      // flush outranks push/pop. The rst branch above outranks flush.
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count_q <= count_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset. Emptiness is tracked by
  // the count and the pointers alone, and the head is masked to zero while
  // empty, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= beat_in;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT head presentation
  // ---------------------------------------------------------------------------
  // The head is read straight from the array at rd_ptr. A beat written at
  // edge N is therefore visible in cycle N+1. While pe_ready is low, neither
  // rd_ptr nor the head entry changes, so pe_* stay stable.
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign bus_pe.pe_valid = ~empty;
  assign bus_pe.pe_ifmap = head.ifmap;
  assign bus_pe.pe_fltr  = head.fltr;
  assign bus_pe.pe_psum  = head.psum;

  assign fifo_count = count_q;
  assign accept_cnt = accept_q;

endmodule : glb_mc_controller

// File: tb/tb_glb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_glb_mc_controller
//
// Self-checking bench for glb_mc_controller (DATA_WIDTH=16, NUM_COL=4,
// FIFO_DEPTH=4).
// Stimulus pushes every beat it expects the DUT to accept into exp_q. A
// separate monitor pops exp_q on each PE handshake and compares the delivered
// beat. Occupancy, READY, latency and counter values are checked inline by the
// stimulus thread.
// Inputs change 1 time unit after a rising edge. Inline checks run at that
// same point. The monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_glb_mc_controller;

  localparam int DW    = 16;
  localparam int NCOL  = 4;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [DW-1:0]   ifmap;
    logic [DW-1:0]   fltr;
    logic [2*DW-1:0] psum;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             cfg_id_we;
  logic [TAG_W-1:0] cfg_id;
  logic             flush;
  logic [CNT_W-1:0] fifo_count;
  logic [15:0]      accept_cnt;

  glb_mc_controller_if #(.DATA_WIDTH(DW), .NUM_COL(NCOL)) bus_pe ();

  glb_mc_controller #(
    .DATA_WIDTH (DW),
    .NUM_COL    (NCOL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_id_we  (cfg_id_we),
    .cfg_id     (cfg_id),
    .flush      (flush),
    .bus_pe     (bus_pe),
    .fifo_count (fifo_count),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  beat_t  exp_q[$];
  logic [15:0] exp_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [TAG_W-1:0] tag, input logic [DW-1:0] ifm,
                            input logic [DW-1:0] flt, input logic [2*DW-1:0] ps);
    bus_pe.bus_valid = 1'b1;
    bus_pe.bus_tag   = tag;
    bus_pe.bus_ifmap = ifm;
    bus_pe.bus_fltr  = flt;
    bus_pe.bus_psum  = ps;
  endtask

  task automatic expect_beat(input logic [DW-1:0] ifm, input logic [DW-1:0] flt,
                             input logic [2*DW-1:0] ps);
    beat_t b;
    b.ifmap = ifm;
    b.fltr  = flt;
    b.psum  = ps;
    exp_q.push_back(b);
  endtask

  task automatic set_id(input logic [TAG_W-1:0] id);
    cfg_id    = id;
    cfg_id_we = 1'b1;
    tick();
    cfg_id_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pe_valid"},   64'(bus_pe.pe_valid),  64'd0);
    check({tag, "_bus_ready"},  64'(bus_pe.bus_ready), 64'd1);
    check({tag, "_fifo_count"}, 64'(fifo_count),       64'd0);
    check({tag, "_accept_cnt"}, 64'(accept_cnt),       64'd0);
    check({tag, "_pe_data"},    {bus_pe.pe_ifmap, bus_pe.pe_fltr, bus_pe.pe_psum}, 64'd0);
  endtask

  // Scoreboard monitor: one comparison per PE handshake that the DUT will
  // honour at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && bus_pe.pe_valid && bus_pe.pe_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pe_unexpected_beat: got 0x%0h, required no beat (t=%0t)",
                 {bus_pe.pe_ifmap, bus_pe.pe_fltr, bus_pe.pe_psum}, $time);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("pe_beat", {bus_pe.pe_ifmap, bus_pe.pe_fltr, bus_pe.pe_psum}, e);
      end
    end
  end

  // Watchdog: the run is a fixed number of cycles, so this only fires if
  // simulation stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    cfg_id_we        = 1'b0;
    cfg_id           = '0;
    flush            = 1'b0;
    bus_pe.bus_valid = 1'b0;
    bus_pe.bus_tag   = '0;
    bus_pe.bus_ifmap = '0;
    bus_pe.bus_fltr  = '0;
    bus_pe.bus_psum  = '0;
    bus_pe.pe_ready  = 1'b0;
    exp_acc          = '0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // ---------------- Test 1: tag filter and 1-cycle latency ----------------
    set_id(2'd2);
    bus_pe.pe_ready = 1'b1;
    drive_beat(2'd1, 16'h0011, 16'h0a01, 32'h0000_0101);
    tick();
    check("t1_tag1_ignored", 64'(fifo_count), 64'd0);
    drive_beat(2'd2, 16'h0022, 16'h0a02, 32'h0000_0202);
    expect_beat(16'h0022, 16'h0a02, 32'h0000_0202);
    exp_acc++;
    tick();
    check("t1_latency_valid", 64'(bus_pe.pe_valid), 64'd1);
    check("t1_latency_ifmap", 64'(bus_pe.pe_ifmap), 64'h0022);
    drive_beat(2'd3, 16'h0033, 16'h0a03, 32'h0000_0303);
    tick();
    check("t1_tag3_ignored", 64'(bus_pe.pe_valid), 64'd0);
    check("t1_accept_cnt", 64'(accept_cnt), 64'(exp_acc));
    bus_pe.bus_valid = 1'b0;

    // ---------------- Test 2: fill to full, backpressure, drain ----------------
    set_id(2'd0);
    bus_pe.pe_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_beat(2'd0, 16'(16'h0100 + i), 16'(16'h0200 + i), 32'(i));
      expect_beat(16'(16'h0100 + i), 16'(16'h0200 + i), 32'(i));
      tick();
      if (i <= 4) exp_acc++;
      if (i == 4) begin
        check("t2_full_count", 64'(fifo_count), 64'd4);
        check("t2_full_ready", 64'(bus_pe.bus_ready), 64'd0);
      end
    end
    check("t2_fifth_held_count", 64'(fifo_count), 64'd4);
    check("t2_fifth_held_acc", 64'(accept_cnt), 64'(exp_acc));
    bus_pe.pe_ready = 1'b1;
    tick();
    check("t2_after_pop_count", 64'(fifo_count), 64'd3);
    check("t2_after_pop_ready", 64'(bus_pe.bus_ready), 64'd1);
    tick();
    exp_acc++;
    check("t2_fifth_accepted_count", 64'(fifo_count), 64'd3);
    check("t2_fifth_accepted_acc", 64'(accept_cnt), 64'(exp_acc));
    bus_pe.bus_valid = 1'b0;
    repeat (3) tick();
    check("t2_drained", 64'(fifo_count), 64'd0);

    // ---------------- Test 3: steady push+pop at occupancy 2 ----------------
    bus_pe.pe_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_beat(2'd0, 16'h0300, 16'(16'h1000 + i), 32'h3000);
      expect_beat(16'h0300, 16'(16'h1000 + i), 32'h3000);
      exp_acc++;
      tick();
    end
    check("t3_preload_count", 64'(fifo_count), 64'd2);
    bus_pe.pe_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_beat(2'd0, 16'h0300, 16'(16'h1002 + k), 32'h3000);
      expect_beat(16'h0300, 16'(16'h1002 + k), 32'h3000);
      exp_acc++;
      tick();
      check("t3_steady_count", 64'(fifo_count), 64'd2);
    end
    bus_pe.bus_valid = 1'b0;
    repeat (2) tick();
    check("t3_drained", 64'(fifo_count), 64'd0);
    check("t3_accept_cnt", 64'(accept_cnt), 64'(exp_acc));

    // ---------------- Test 4: ID change uses old ID in the same cycle ----------------
    bus_pe.pe_ready = 1'b0;
    cfg_id    = 2'd1;
    cfg_id_we = 1'b1;
    drive_beat(2'd0, 16'h0440, 16'h0441, 32'h0000_0442);
    expect_beat(16'h0440, 16'h0441, 32'h0000_0442);
    exp_acc++;
    tick();
    cfg_id_we = 1'b0;
    check("t4_old_id_accept", 64'(fifo_count), 64'd1);
    drive_beat(2'd0, 16'h0450, 16'h0451, 32'h0000_0452);
    tick();
    check("t4_new_id_reject_count", 64'(fifo_count), 64'd1);
    check("t4_new_id_reject_acc", 64'(accept_cnt), 64'(exp_acc));
    drive_beat(2'd1, 16'h0460, 16'h0461, 32'h0000_0462);
    expect_beat(16'h0460, 16'h0461, 32'h0000_0462);
    exp_acc++;
    tick();
    check("t4_new_id_accept", 64'(fifo_count), 64'd2);
    bus_pe.bus_valid = 1'b0;
    bus_pe.pe_ready  = 1'b1;
    repeat (2) tick();
    check("t4_drained", 64'(fifo_count), 64'd0);

    // ---------------- Test 5: flush with coincident push, then mid-stream reset ----------------
    bus_pe.pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(2'd1, 16'(16'h0500 + i), 16'h0501, 32'h0000_0500);
      exp_acc++;
      tick();
    end
    check("t5_preflush_count", 64'(fifo_count), 64'd3);
    flush = 1'b1;
    drive_beat(2'd1, 16'h05ff, 16'h05ff, 32'h0000_05ff);
    tick();
    flush = 1'b0;
    bus_pe.bus_valid = 1'b0;
    check("t5_flush_count", 64'(fifo_count), 64'd0);
    check("t5_flush_valid", 64'(bus_pe.pe_valid), 64'd0);
    check("t5_flush_acc", 64'(accept_cnt), 64'(exp_acc));
    for (int i = 0; i < 2; i++) begin
      drive_beat(2'd1, 16'(16'h0600 + i), 16'h0601, 32'h0000_0600);
      tick();
    end
    bus_pe.bus_valid = 1'b0;
    check("t5_prereset_count", 64'(fifo_count), 64'd2);
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_reset");
    rst = 1'b0;
    exp_acc = '0;
    bus_pe.pe_ready = 1'b1;
    repeat (3) tick();
    check("t5_nothing_delivered", 64'(bus_pe.pe_valid), 64'd0);

    // ---------------- Test 6: accept_cnt wrap ----------------
    // The ID is back to 0 after reset, so tag-0 beats must be accepted here.
    for (int i = 1; i <= 65535; i++) begin
      drive_beat(2'd0, 16'(i), ~16'(i), {16'(i), 16'(i)});
      expect_beat(16'(i), ~16'(i), {16'(i), 16'(i)});
      tick();
    end
    check("t6_acc_ffff", 64'(accept_cnt), 64'hffff);
    drive_beat(2'd0, 16'hbeef, 16'hcafe, 32'hdead_0001);
    expect_beat(16'hbeef, 16'hcafe, 32'hdead_0001);
    tick();
    check("t6_acc_wrap", 64'(accept_cnt), 64'h0000);
    bus_pe.bus_valid = 1'b0;
    repeat (2) tick();
    check("t6_drained", 64'(fifo_count), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_glb_mc_controller
